// File: rtl/leap_mem_responder.sv
// Single-port word memory answering level-held write/read requests through an IDLE/WAIT/ACK/RECOVER handshake.
// Latency: ack is high LATENCY cycles after the accepting edge, for one cycle; one RECOVER cycle follows.
// Backpressure: requests are taken only in IDLE; the initiator holds its request level until the matching ack.
module leap_mem_responder #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_LOG2_DEPTH = 10,
   parameter int LATENCY        = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  writeReq,
   input  logic [ADDR_WIDTH-1:0] writeReq_addr,
   input  logic [DATA_WIDTH-1:0] writeReq_data,
   output logic                  writeAck,
   input  logic                  readReq,
   input  logic [ADDR_WIDTH-1:0] readReq_addr,
   output logic                  readAck,
   output logic [DATA_WIDTH-1:0] readReq_data,
   output logic                  busy,
   output logic [31:0]           wr_count,
   output logic [31:0]           rd_count,
   output logic [15:0]           oob_count
);

   localparam int MEM_DEPTH = 2 ** MEM_LOG2_DEPTH;
   // Counter preload: WAIT lasts LATENCY-1 cycles, then one ACK cycle.
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACK     = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  is_wr_q, is_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            lat_cnt_q, lat_cnt_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [31:0]           wr_cnt_q, wr_cnt_d;
   logic [31:0]           rd_cnt_q, rd_cnt_d;
   logic [15:0]           oob_cnt_q, oob_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic                  in_range_q;
   logic                  mem_we;

   // Range check of the latched address: every bit above the memory index must be zero.
   assign in_range_q = ((addr_q >> MEM_LOG2_DEPTH) == '0);
   // Writes commit on the edge that ends the writeAck cycle, only when in range.
   assign mem_we     = (state_q == ACK) && is_wr_q && in_range_q;

   assign writeAck     = (state_q == ACK) && is_wr_q;
   assign readAck      = (state_q == ACK) && !is_wr_q;
   assign readReq_data = rd_data_q;
   assign busy         = (state_q != IDLE);
   assign wr_count     = wr_cnt_q;
   assign rd_count     = rd_cnt_q;
   assign oob_count    = oob_cnt_q;

   // Next-state, request latching, read data capture and completion counters.
   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      lat_cnt_d = lat_cnt_q;
      rd_data_d = rd_data_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      oob_cnt_d = oob_cnt_q;

      case (state_q)
         IDLE: begin
            // Write wins a tie; the read stays pending and is taken after RECOVER.
            if (writeReq) begin
               is_wr_d   = 1'b1;
               addr_d    = writeReq_addr;
               wdata_d   = writeReq_data;
               lat_cnt_d = LAT_LOAD;
               state_d   = (LATENCY == 1) ? ACK : WAIT;
            end else if (readReq) begin
               is_wr_d   = 1'b0;
               addr_d    = readReq_addr;
               lat_cnt_d = LAT_LOAD;
               state_d   = (LATENCY == 1) ? ACK : WAIT;
            end
         end
         WAIT: begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q <= 4'd1) begin
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = RECOVER;
            if (is_wr_q) begin
               wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
               rd_cnt_d = rd_cnt_q + 32'd1;
            end
            if (!in_range_q && (oob_cnt_q != 16'hFFFF)) begin
               oob_cnt_d = oob_cnt_q + 16'd1;
            end
         end
         RECOVER: begin
            // One dead cycle so a still-held, already-acked request is not re-accepted.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Read data is captured on the edge entering ACK so it is valid throughout readAck.
      if ((state_d == ACK) && (state_q != ACK) && !is_wr_d) begin
         if ((addr_d >> MEM_LOG2_DEPTH) == '0) begin
            rd_data_d = mem_q[addr_d[MEM_LOG2_DEPTH-1:0]];
         end else begin
            rd_data_d = '0;
         end
      end
   end

   // Control and status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lat_cnt_q <= 4'd0;
         rd_data_q <= '0;
         wr_cnt_q  <= 32'd0;
         rd_cnt_q  <= 32'd0;
         oob_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lat_cnt_q <= lat_cnt_d;
         rd_data_q <= rd_data_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         oob_cnt_q <= oob_cnt_d;
      end
   end

   // Memory array: never cleared, and a reset edge suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem_q[addr_q[MEM_LOG2_DEPTH-1:0]] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_leap_mem_responder.sv
// Directed bench for leap_mem_responder: LATENCY=4 instance for data path, priority, range and reset,
// plus a LATENCY=1 instance for back-to-back acceptance of a held request.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_leap_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        wr_req, rd_req;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic        wr_ack, rd_ack, busy;
   logic [31:0] rd_data, wr_cnt, rd_cnt;
   logic [15:0] oob_cnt;

   logic        wr_req1, rd_req1;
   logic [31:0] wr_addr1, wr_data1, rd_addr1;
   logic        wr_ack1, rd_ack1, busy1;
   logic [31:0] rd_data1, wr_cnt1, rd_cnt1;
   logic [15:0] oob_cnt1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   leap_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LOG2_DEPTH(10), .LATENCY(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .writeReq(wr_req), .writeReq_addr(wr_addr), .writeReq_data(wr_data), .writeAck(wr_ack),
      .readReq(rd_req), .readReq_addr(rd_addr), .readAck(rd_ack), .readReq_data(rd_data),
      .busy(busy), .wr_count(wr_cnt), .rd_count(rd_cnt), .oob_count(oob_cnt)
   );

   leap_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LOG2_DEPTH(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .writeReq(wr_req1), .writeReq_addr(wr_addr1), .writeReq_data(wr_data1), .writeAck(wr_ack1),
      .readReq(rd_req1), .readReq_addr(rd_addr1), .readAck(rd_ack1), .readReq_data(rd_data1),
      .busy(busy1), .wr_count(wr_cnt1), .rd_count(rd_cnt1), .oob_count(oob_cnt1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise one request on the LATENCY=4 instance and follow it until the DUT is idle again.
   task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output int lat, output int acks, output int wrong, output int busy_n,
                       output logic [31:0] dat);
      lat = -1; acks = 0; wrong = 0; busy_n = 0; dat = '0;
      if (wr) begin
         wr_req = 1'b1; wr_addr = addr; wr_data = data;
      end else begin
         rd_req = 1'b1; rd_addr = addr;
      end
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (busy) busy_n++;
         if (wr ? wr_ack : rd_ack) begin
            acks++;
            if (lat < 0) lat = n;
            dat = rd_data;
            if (wr) wr_req = 1'b0; else rd_req = 1'b0;
         end
         if (wr ? rd_ack : wr_ack) wrong++;
         if (!busy) break;
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before test end");
      $fatal(1, "timeout");
   end

   initial begin
      int          lat, acks, wrong, busy_n, wa, ra, ack_seen;
      logic [31:0] dat, rdat, mask;

      rst_n = 1'b0;
      wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      // Request held through reset on the LATENCY=1 instance.
      wr_req1 = 1'b1; wr_addr1 = 32'h9; wr_data1 = 32'h99; rd_req1 = 1'b0; rd_addr1 = '0;
      repeat (3) tick();

      check("rst_busy",    {31'd0, busy},   32'd0);
      check("rst_wack",    {31'd0, wr_ack}, 32'd0);
      check("rst_rack",    {31'd0, rd_ack}, 32'd0);
      check("rst_rdata",   rd_data,         32'd0);
      check("rst_wrcnt",   wr_cnt,          32'd0);
      check("rst_rdcnt",   rd_cnt,          32'd0);
      check("rst_oob",     {16'd0, oob_cnt}, 32'd0);
      check("rst_busy_l1", {31'd0, busy1},  32'd0);
      check("rst_wrcnt_l1", wr_cnt1,        32'd0);

      // LATENCY=1: accept on the first edge after release, then every 3 cycles while held.
      rst_n = 1'b1;
      mask = '0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (wr_ack1) mask[n] = 1'b1;
         if (n == 7) wr_req1 = 1'b0;
      end
      check("l1_ack_pattern", mask,    32'h0000_0092);
      check("l1_wrcnt",       wr_cnt1, 32'd3);

      // Basic write then read at LATENCY=4.
      xact(1'b1, 32'h5, 32'hDEAD_BEEF, lat, acks, wrong, busy_n, dat);
      check("wr_latency", lat,    32'd4);
      check("wr_acks",    acks,   32'd1);
      check("wr_wrong",   wrong,  32'd0);
      check("wr_busy_n",  busy_n, 32'd5);
      check("wr_count1",  wr_cnt, 32'd1);

      xact(1'b0, 32'h5, 32'h0, lat, acks, wrong, busy_n, dat);
      check("rd_latency", lat,     32'd4);
      check("rd_acks",    acks,    32'd1);
      check("rd_wrong",   wrong,   32'd0);
      check("rd_data",    dat,     32'hDEAD_BEEF);
      check("rd_count1",  rd_cnt,  32'd1);
      check("rd_hold",    rd_data, 32'hDEAD_BEEF);

      // Simultaneous write and read: write first, read accepted after RECOVER.
      wr_req = 1'b1; wr_addr = 32'h7; wr_data = 32'h1234;
      rd_req = 1'b1; rd_addr = 32'h7;
      wa = -1; ra = -1; rdat = '0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (wr_ack) begin
            if (wa < 0) wa = n;
            wr_req = 1'b0;
         end
         if (rd_ack) begin
            if (ra < 0) ra = n;
            rdat = rd_data;
            rd_req = 1'b0;
         end
         if (!rd_req && !busy) break;
      end
      wr_req = 1'b0; rd_req = 1'b0;
      check("prio_wr_cycle", wa,     32'd4);
      check("prio_rd_cycle", ra,     32'd10);
      check("prio_rd_data",  rdat,   32'h1234);
      check("prio_wrcnt",    wr_cnt, 32'd2);
      check("prio_rdcnt",    rd_cnt, 32'd2);

      // Out-of-range read and write.
      xact(1'b1, 32'h0, 32'hA5A5_A5A5, lat, acks, wrong, busy_n, dat);
      xact(1'b0, 32'h0000_0400, 32'h0, lat, acks, wrong, busy_n, dat);
      check("oob_rd_acks", acks,            32'd1);
      check("oob_rd_data", dat,             32'd0);
      check("oob_cnt1",    {16'd0, oob_cnt}, 32'd1);
      xact(1'b1, 32'h0000_0400, 32'hBAD0_BAD0, lat, acks, wrong, busy_n, dat);
      check("oob_wr_acks", acks,            32'd1);
      check("oob_cnt2",    {16'd0, oob_cnt}, 32'd2);
      xact(1'b0, 32'h0, 32'h0, lat, acks, wrong, busy_n, dat);
      check("oob_word0",   dat,    32'hA5A5_A5A5);
      check("oob_wrcnt",   wr_cnt, 32'd4);
      check("oob_rdcnt",   rd_cnt, 32'd4);

      // Reset during WAIT of a write drops it without ack or memory update.
      xact(1'b1, 32'h3, 32'h3333_3333, lat, acks, wrong, busy_n, dat);
      wr_req = 1'b1; wr_addr = 32'h3; wr_data = 32'hFFFF_FFFF;
      tick();
      tick();
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      wr_req = 1'b0;
      ack_seen = 0;
      tick();
      if (wr_ack) ack_seen++;
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (wr_ack) ack_seen++;
      end
      check("mrst_no_ack", ack_seen,         32'd0);
      check("mrst_busy",   {31'd0, busy},    32'd0);
      check("mrst_wrcnt",  wr_cnt,           32'd0);
      check("mrst_rdcnt",  rd_cnt,           32'd0);
      check("mrst_oob",    {16'd0, oob_cnt}, 32'd0);
      check("mrst_rdata",  rd_data,          32'd0);
      xact(1'b0, 32'h3, 32'h0, lat, acks, wrong, busy_n, dat);
      check("mrst_word3",  dat,    32'h3333_3333);
      check("mrst_rdcnt1", rd_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
